// File: rtl/image_filter_pkg.sv
// Shared pixel/window types and datapath widths for the median + Sobel edge filter.
package image_filter_pkg;

  localparam int PIX_W      = 8;
  localparam int ACC_W      = 12;
  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;

  typedef logic [PIX_W-1:0] pixel_t;
  // Indexed [row][col]; row 0 is the oldest line, col 0 the oldest column.
  typedef pixel_t [2:0][2:0] window_t;

  function automatic logic signed [ACC_W-1:0] widen(input pixel_t p);
    return $signed({{(ACC_W-PIX_W){1'b0}}, p});
  endfunction

endpackage

// File: rtl/image_filter_window_3x3.sv
// Two line buffers feeding a 3x3 window; window and win_vld register on the accepting edge.
// No backpressure: every pix_vld is consumed; win_vld only for row>=2, col>=2 of the current frame.
module window_3x3
  import image_filter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic    clk,
  input  logic    rst,
  input  pixel_t  pix,
  input  logic    pix_vld,
  output window_t win,
  output logic    win_vld
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pixel_t        line1 [WIDTH];
  pixel_t        line2 [WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      win_vld <= 1'b0;
    end else begin
      win_vld <= pix_vld && (row >= RW'(2)) && (col >= CW'(2));
      if (pix_vld) begin
        if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stale data from earlier frames is harmless: the row/col gating never exposes it.
  always_ff @(posedge clk) begin
    if (pix_vld && !rst) begin
      line1[col] <= pix;
      line2[col] <= line1[col];
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= line2[col];
      win[1][2] <= line1[col];
      win[2][2] <= pix;
    end
  end

endmodule

// File: rtl/image_filter_top.sv
// 3x3 median then 3x3 Sobel magnitude; 3 edges from accepting edge to valid_out, no backpressure.
// Optional SOBEL_THRESH_EN binarizes the magnitude against THRESHOLD with identical timing.
module image_filter_top
  import image_filter_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_HEIGHT,
  parameter int THRESHOLD    = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             valid_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             valid_out
);

  if (IMAGE_WIDTH < 5 || IMAGE_HEIGHT < 5) begin : g_bad_size
    $error("image_filter_top: image must be at least 5x5");
  end
  if (THRESHOLD < 0 || THRESHOLD > 4095) begin : g_bad_thresh
    $error("image_filter_top: THRESHOLD outside magnitude range");
  end

  window_t win1, win2;
  logic    win1_vld, win2_vld;
  pixel_t  med_pix;
  logic    med_vld;

  window_3x3 #(.WIDTH(IMAGE_WIDTH), .HEIGHT(IMAGE_HEIGHT)) u_med_win (
    .clk     (clk),
    .rst     (rst),
    .pix     (pixel_in),
    .pix_vld (valid_in),
    .win     (win1),
    .win_vld (win1_vld)
  );

  // Median as the element of rank 4; ties broken by position so exactly one element wins.
  pixel_t     mp   [9];
  logic [3:0] rank [9];
  pixel_t     med_val;

  always_comb begin
    med_val = '0;
    for (int i = 0; i < 9; i++) begin
      mp[i]   = win1[i / 3][i % 3];
      rank[i] = '0;
    end
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 9; j++) begin
        if (mp[j] < mp[i] || (mp[j] == mp[i] && j < i)) rank[i] = rank[i] + 4'd1;
      end
      if (rank[i] == 4'd4) med_val = mp[i];
    end
  end

  window_3x3 #(.WIDTH(IMAGE_WIDTH - 2), .HEIGHT(IMAGE_HEIGHT - 2)) u_sob_win (
    .clk     (clk),
    .rst     (rst),
    .pix     (med_pix),
    .pix_vld (med_vld),
    .win     (win2),
    .win_vld (win2_vld)
  );

  logic signed [ACC_W-1:0] gx, gy;
  logic        [ACC_W-1:0] ax, ay, mag;
  pixel_t                  sob_val;

  always_comb begin
    gx = (widen(win2[0][2]) + (widen(win2[1][2]) <<< 1) + widen(win2[2][2]))
       - (widen(win2[0][0]) + (widen(win2[1][0]) <<< 1) + widen(win2[2][0]));
    gy = (widen(win2[2][0]) + (widen(win2[2][1]) <<< 1) + widen(win2[2][2]))
       - (widen(win2[0][0]) + (widen(win2[0][1]) <<< 1) + widen(win2[0][2]));
    ax  = gx[ACC_W-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[ACC_W-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
`ifdef SOBEL_THRESH_EN
    sob_val = (mag >= ACC_W'(THRESHOLD)) ? '1 : '0;
`else
    sob_val = (mag > ACC_W'(255)) ? '1 : mag[PIX_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      med_vld   <= 1'b0;
      med_pix   <= '0;
      valid_out <= 1'b0;
      pixel_out <= '0;
    end else begin
      med_vld   <= win1_vld;
      valid_out <= win2_vld;
      if (win1_vld) med_pix   <= med_val;
      if (win2_vld) pixel_out <= sob_val;
    end
  end

endmodule

// File: tb/tb_image_filter_top.sv
// Directed frames on a reduced 16x12 image; a frame-based golden model fills the scoreboard queue.
module tb_image_filter_top;

  localparam int TW   = 16;
  localparam int TH   = 12;
  localparam int TTH  = 100;
  localparam int NPIX = TW * TH;
  localparam int NOUT = (TW - 4) * (TH - 4);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pixel_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] pixel_out;
  logic       valid_out;

  int         errors = 0;
  int         checks = 0;
  int         seen = 0;
  logic [7:0] last_out = '0;
  int         img [TH][TW];
  int         exp_q [$];

  image_filter_top #(.IMAGE_WIDTH(TW), .IMAGE_HEIGHT(TH), .THRESHOLD(TTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pixel_in  (pixel_in),
    .valid_in  (valid_in),
    .pixel_out (pixel_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      seen++;
      if (exp_q.size() == 0) check("unexpected_valid_out", valid_out, 0);
      else check("pixel_out", pixel_out, exp_q.pop_front());
      last_out = pixel_out;
    end else if (rst) begin
      last_out = '0;
    end else begin
      check("hold_pixel_out", pixel_out, last_out);
    end
  end

  task automatic fill(input int kind);
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r == 5 && c == 5) ? 255 : 0;
          2:       img[r][c] = (c < TW / 2) ? 0 : 200;
          3:       img[r][c] = r;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  // Push expected outputs whose completing input pixel index is below limit.
  task automatic push_expect(input int limit);
    int med [TH-2][TW-2];
    int w [9];
    int t, gx, gy, m;
    for (int r = 0; r < TH - 2; r++)
      for (int c = 0; c < TW - 2; c++) begin
        for (int k = 0; k < 9; k++) w[k] = img[r + k / 3][c + k % 3];
        for (int a = 0; a < 9; a++)
          for (int b = 0; b < 8 - a; b++)
            if (w[b] > w[b + 1]) begin
              t = w[b]; w[b] = w[b + 1]; w[b + 1] = t;
            end
        med[r][c] = w[4];
      end
    for (int r = 0; r < TH - 4; r++)
      for (int c = 0; c < TW - 4; c++)
        if ((r + 4) * TW + (c + 4) < limit) begin
          gx = (med[r][c+2] + 2 * med[r+1][c+2] + med[r+2][c+2])
             - (med[r][c] + 2 * med[r+1][c] + med[r+2][c]);
          gy = (med[r+2][c] + 2 * med[r+2][c+1] + med[r+2][c+2])
             - (med[r][c] + 2 * med[r][c+1] + med[r][c+2]);
          m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
          m = (m >= TTH) ? 255 : 0;
`else
          if (m > 255) m = 255;
`endif
          exp_q.push_back(m);
        end
  endtask

  task automatic drive(input int n, input int idle_pct);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < idle_pct) begin
        valid_in = 1'b0;
        pixel_in = 8'($urandom);
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      pixel_in = 8'(img[i / TW][i % TW]);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain(input string tag, input int start);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk); #1;
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_count"}, seen - start, NOUT);
    exp_q.delete();
  endtask

  int start;

  initial begin
    rst      = 1'b1;
    valid_in = 1'b1;
    pixel_in = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out", valid_out, 0);
    check("reset_pixel_out", pixel_out, 0);
    rst      = 1'b0;
    valid_in = 1'b0;
    @(posedge clk); #1;

    // Constant, impulse, step and ramp frames, no reset between them.
    for (int kind = 0; kind < 4; kind++) begin
      start = seen;
      fill(kind);
      push_expect(NPIX);
      drive(NPIX, 0);
      if (kind == 0) begin
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("latency_2_edges_pending", exp_q.size(), 1);
        @(negedge clk); #1;
        check("latency_3_edges_done", exp_q.size(), 0);
      end
      drain($sformatf("frame%0d", kind), start);
    end

    // Abort mid-frame right after a completing pixel; the last three in-flight results die.
    fill(4);
    push_expect(6 * TW + 10 - 3);
    drive(6 * TW + 10, 0);
    rst      = 1'b1;
    valid_in = 1'b1;
    pixel_in = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("midreset_valid_out", valid_out, 0);
    check("midreset_pixel_out", pixel_out, 0);
    check("midreset_queue", exp_q.size(), 0);
    rst      = 1'b0;
    valid_in = 1'b0;
    @(posedge clk); #1;

    fill(4);
    start = seen;
    push_expect(NPIX);
    drive(NPIX, 0);
    drain("post_reset", start);

    // Same image again with idle gaps; output must match the gap-free frame.
    start = seen;
    push_expect(NPIX);
    drive(NPIX, 30);
    drain("gaps", start);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_filter_top.md
IMAGE_FILTER_TOP -- requirements
Module: image_filter_top

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 320, pixels per row.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 240, rows per frame.
REQ-003 SHALL have parameter THRESHOLD, default 100, binarization level, used only under REQ-025.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pixel_in, input, 8, grayscale input pixel, raster order.
REQ-007 SHALL have port valid_in, input, 1, pixel_in accepted on each rising edge where high.
REQ-008 SHALL have port pixel_out, output, 8, filtered edge-magnitude pixel.
REQ-009 SHALL have port valid_out, output, 1, one-cycle qualifier per output pixel.

Function
REQ-010 SHALL form two cascaded stages: 3x3 median filter, then 3x3 Sobel edge magnitude.
REQ-011 SHALL have no backpressure; every valid_in pulse is consumed, and gaps in valid_in are allowed at any point.
REQ-012 Median stage SHALL track input (row, col) and wrap col at IMAGE_WIDTH-1 and row at IMAGE_HEIGHT-1 (new frame).
REQ-013 Median stage SHALL emit one output only for accepted pixels with row>=2 and col>=2, giving a (H-2)x(W-2) stream; no padding and no cross-row windows.
REQ-014 Median output SHALL be the exact 5th-smallest of the 9 window pixels, unsigned 8-bit.
REQ-015 Sobel stage SHALL treat the median stream as an image of width W-2 and height H-2, with its own row/col counters, and emit only for row>=2, col>=2, giving (H-4)x(W-4)=74576 outputs per default frame.
REQ-016 Sobel SHALL compute Gx=[-1 0 1;-2 0 2;-1 0 1] and Gy=[-1 -2 -1;0 0 0;1 2 1] in signed arithmetic of at least 12 bits; magnitude=|Gx|+|Gy|, saturated to 255.
REQ-017 Latency: median result SHALL be registered 1 edge after the accepting edge; the Sobel window SHALL update 1 edge later; pixel_out/valid_out SHALL be registered 1 edge after that, for 3 edges total from the accepting edge of the completing input pixel.
REQ-018 valid_out SHALL be high exactly one cycle per output pixel, and pixel_out SHALL hold its last value when valid_out is low.
REQ-019 Line buffers SHALL hold two previous rows per stage (depth W and W-2); stored contents from a prior frame SHALL never produce an output, per the row>=2 gating.
REQ-020 After the last frame pixel, all outputs SHALL appear within 3 cycles with no further valid_in; no flush input is needed.

Reset
REQ-021 rst SHALL clear all row/col counters, all valid pipeline bits, valid_out=0, and pixel_out=0.
REQ-022 Line-buffer and window contents SHALL NOT require reset.
REQ-023 Reset mid-frame SHALL abort the frame; the next accepted pixel SHALL be row 0, col 0, and no output SHALL derive from pre-reset pixels.
REQ-024 valid_in during rst SHALL be ignored.

Configuration
REQ-025 With macro SOBEL_THRESH_EN defined, pixel_out SHALL be 255 if magnitude>=THRESHOLD, else 0; without it, pixel_out SHALL be the saturated magnitude per REQ-016; timing SHALL be identical in both cases.

Structure
REQ-026 Package image_filter_pkg SHALL hold the pixel width (8), the Sobel accumulator width, the default WIDTH/HEIGHT constants and the pixel typedef.
REQ-027 Sub-module window_3x3 (line buffers + 3x3 register window + row/col counters + window-valid flag, parameterized by width) SHALL be instantiated twice, and the median and Sobel datapaths SHALL reside in the top level.

Verification
REQ-028 Constant frame 100, 320x240 -> exactly 74576 valid_out pulses, all pixel_out=0.
REQ-029 Flat 0 frame with a single 255 impulse at (100,100) -> all pixel_out=0 (impulse removed by median).
REQ-030 Vertical step: col<160 ->0, else 200 -> 255 (saturated) at Sobel columns adjacent to the step, 0 elsewhere; count 74576.
REQ-031 Vertical ramp pixel=row -> all pixel_out=8; with SOBEL_THRESH_EN and THRESHOLD=100 -> all 0.
REQ-032 Reset asserted mid-frame after 5000 pixels, then a full frame -> no valid_out after reset until the new frame's window fills, and exactly 74576 outputs matching a golden model.
REQ-033 Random valid_in gaps (~30% idle) with a random image -> output sequence identical to the gap-free run.
